// File: rtl/product_accumulator.sv
// Saturating accumulator for signed multiplier products: sums a group of beats
// and presents sum, beat count and sticky overflow on a valid/ready result port.
module product_accumulator #(
  parameter int PROD_W = 64,
  parameter int ACC_W  = 72,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] in_prod,
  input  logic                     in_last,
  input  logic                     clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  // The sum carries one guard bit; a mismatch between the top two bits means
  // the true value lies outside the ACC_W range and must clamp.
  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    if (s[ACC_W] == s[ACC_W-1]) begin
      return s[ACC_W-1:0];
    end else if (s[ACC_W]) begin
      return ACC_MIN;
    end else begin
      return ACC_MAX;
    end
  endfunction

  function automatic logic sat_hit(input logic signed [ACC_W:0] s);
    return s[ACC_W] != s[ACC_W-1];
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  state_t                    state_q, state_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic                      out_valid_q, out_valid_d;
  logic signed [ACC_W-1:0]   out_acc_q, out_acc_d;
  logic [CNT_W-1:0]          out_count_q, out_count_d;
  logic                      out_ovf_q, out_ovf_d;

  logic                      accept;
  logic signed [ACC_W:0]     acc_ext;
  logic signed [ACC_W:0]     prod_ext;
  logic signed [ACC_W:0]     sum;
  logic signed [ACC_W-1:0]   acc_new;
  logic [CNT_W-1:0]          cnt_new;
  logic                      ovf_new;

  assign in_ready = (state_q != HOLD) && !clear;
  assign accept   = in_valid && in_ready;

  assign acc_ext  = {acc_q[ACC_W-1], acc_q};
  assign prod_ext = {{(ACC_W+1-PROD_W){in_prod[PROD_W-1]}}, in_prod};
  assign sum      = acc_ext + prod_ext;
  assign acc_new  = sat_acc(sum);
  assign cnt_new  = cnt_inc(cnt_q);
  assign ovf_new  = ovf_q | sat_hit(sum);

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_acc_d   = out_acc_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    case (state_q)
      HOLD: begin
        // Result registers are frozen here; clear has no effect until drained.
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        if (clear) begin
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          state_d = IDLE;
        end else if (accept) begin
          if (in_last) begin
            out_acc_d   = acc_new;
            out_count_d = cnt_new;
            out_ovf_d   = ovf_new;
            out_valid_d = 1'b1;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            state_d     = HOLD;
          end else begin
            acc_d   = acc_new;
            cnt_d   = cnt_new;
            ovf_d   = ovf_new;
            state_d = ACCUM;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_acc_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_acc_q   <= out_acc_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_acc   = out_acc_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule
